icache_l1: RTL and testbench
============================

// Module: icache_l1
// PURPOSE
//  Direct-mapped L1 instruction cache for the fetch stage. Returns instr_f_o for pc_f_i combinationally on a hit.
//  On a miss it refills one line from the memory port. It drives instr_miss_f_o and instr_cache_rep_en_o into
//  hazard_unit, which turns them into stall_f..stall_w and the E-stage flush qualifier.
// PARAMETERS
//  SETS        64  number of lines (power of 2); index width IDX_W = log2(SETS)
//  LINE_WORDS  4   32-bit words per line (power of 2); offset width OFF_W = log2(LINE_WORDS)
//  TAG_W       derived = 32 - IDX_W - OFF_W - 2 (22 at defaults)
// PORTS
//  clk_i                in   1   clock; all state updates on rising edge
//  reset_i              in   1   asynchronous, active-high reset
//  pc_f_i               in   32  fetch byte address; bits[1:0] ignored
//  inv_all_i            in   1   fence.i: invalidate every line
//  instr_f_o            out  32  instruction word for pc_f_i; valid only when instr_miss_f_o=0
//  instr_miss_f_o       out  1   fetch cannot complete this cycle
//  instr_cache_rep_en_o out  1   line replacement is committing this cycle
//  mem_req_o            out  1   refill request, level-held for the whole burst
//  mem_addr_o           out  32  byte address of the word currently requested
//  mem_rdata_i          in   32  refill data
//  mem_rvalid_i         in   1   mem_rdata_i valid for mem_addr_o this cycle
// BEHAVIOUR
//  Reset: state=IDLE, all valid bits=0, beat_cnt=0, inv_pend=0, mem_req_o=0, rep_en=0, miss=1 (lines invalid).
//  Address split: tag=pc[31:32-TAG_W], idx=pc[OFF_W+IDX_W+1:OFF_W+2], off=pc[OFF_W+1:2].
//  IDLE:
//   - hit = valid[idx] & tag match; miss_o = ~hit; instr_f_o = data[idx][off] (same cycle, no latency).
//   - On a miss, latch line base {tag,idx,0} into fill_addr, clear beat_cnt, go to REFILL.
//  REFILL:
//   - mem_req_o=1; mem_addr_o = fill_addr + 4*beat_cnt. Words are written into a line buffer in order.
//   - Each mem_rvalid_i stores mem_rdata_i at beat_cnt, then beat_cnt++.
//   - When the LINE_WORDS-1 beat is accepted, go to COMMIT. Any number of wait cycles is legal. miss_o=1.
//  COMMIT (1 cycle):
//   - rep_en_o=1, miss_o=1, mem_req_o=0.
//   - Write the buffer, the tag and valid=1 into fill_addr's set, then go to IDLE.
//  Refill-to-hit latency: miss cycle + LINE_WORDS beats + 1 commit; the first IDLE cycle after COMMIT hits.
//  pc_f_i may change during REFILL (branch redirect): the fill always completes for the latched fill_addr.
//   Lookup then uses the new pc, which may miss again. A refill is never aborted.
//  inv_all_i:
//   - In IDLE: clear all valid bits at the edge. Lookup in that same cycle still uses the old valid bits.
//   - In REFILL/COMMIT: set inv_pend. In the first IDLE cycle inv_pend clears all valids (including the
//     just-committed line) and clears itself. That cycle miss_o=1 regardless of tag.
//  Simultaneous mem_rvalid_i in COMMIT or IDLE: ignored.
//  reset_i mid-REFILL: immediate return to reset state; the partial line is discarded; mem_req_o drops asynchronously.
//  Set-index wrap: mem_addr_o never crosses the line; beat_cnt wraps naturally at LINE_WORDS.
// STRUCTURE
//  icache_pkg (shared):
//   - typedef enum logic [1:0] {IC_IDLE, IC_REFILL, IC_COMMIT} icache_state_t
//   - width localparam functions for IDX_W/OFF_W/TAG_W
//  Sub-module icache_store:
//   - tag/valid/data arrays; async read by idx/off
//   - one-cycle line write port (we, idx, tag, line[LINE_WORDS*32])
//   - clear_all input for valid bits; valid array reset by reset_i
//  icache_l1 holds the FSM, beat counter, line buffer, fill_addr and inv_pend.
// TESTING
//  1 Cold miss:
//    - stimulus: reset, pc=0x0000_0040; memory returns 0xA0..A3 with rvalid every cycle
//    - response: miss=1 for 6 cycles; mem_addr 0x40,0x44,0x48,0x4C; rep_en pulses once;
//      next cycle miss=0, instr=word at 0x40
//  2 Hit sweep:
//    - stimulus: after test 1, pc=0x44, then 0x48, then 0x4C
//    - response: miss=0 each cycle; instr=A1, A2, A3; mem_req stays 0
//  3 Conflict eviction:
//    - stimulus: pc=0x0000_1040 (same idx, new tag)
//    - response: refill with rep_en=1; then pc=0x40 misses again and refills
//  4 Redirect mid-refill with stalled memory:
//    - stimulus: pc=0x80 miss; rvalid gaps of 3 cycles; pc changes to 0x200 after beat 1
//    - response: fill of 0x80..0x8C completes; then 0x200 misses and refills
//  5 fence.i:
//    - stimulus: inv_all_i in IDLE after warm lines
//    - response: next cycle pc=0x40 misses
//    - stimulus: inv_all_i during REFILL
//    - response: committed line is invalid in the first IDLE cycle; miss=1
//  6 Reset mid-REFILL:
//    - stimulus: assert reset_i after beat 2
//    - response: mem_req_o=0 at once; all lines invalid; beat_cnt=0; a fresh miss refill starts at beat 0

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and width helpers for the L1 instruction cache.
// Widths derive from the set count and words per line.
package icache_pkg;

  typedef enum logic [1:0] {
    IC_IDLE,
    IC_REFILL,
    IC_COMMIT
  } icache_state_t;

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int tag_w(input int sets, input int words);
    return 32 - $clog2(sets) - $clog2(words) - 2;
  endfunction

endpackage

// File: rtl/icache_store.sv
// Tag, valid and data arrays of the direct-mapped instruction cache.
// Asynchronous read by index/offset, whole-line write, bulk valid clear.
module icache_store
  import icache_pkg::*;
#(
  parameter int SETS = 64,
  parameter int LINE_WORDS = 4,
  localparam int IDX_W = idx_w(SETS),
  localparam int OFF_W = off_w(LINE_WORDS),
  localparam int TAG_W = tag_w(SETS, LINE_WORDS),
  localparam int LINE_W = LINE_WORDS * 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [OFF_W-1:0]  rd_off,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [31:0]       rd_data,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line,
  input  logic              clear_all
);

  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags  [SETS];
  logic [LINE_W-1:0] lines [SETS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (clear_all) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data need no reset: a line is only read when its valid bit is set.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[wr_idx]  <= wr_tag;
      lines[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = lines[rd_idx][{rd_off, 5'b0} +: 32];

endmodule

// File: rtl/icache_l1.sv
// Direct-mapped L1 instruction cache: combinational hit path,
// in-order line refill through a buffer, one-cycle commit.
module icache_l1
  import icache_pkg::*;
#(
  parameter int SETS = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] pc_f_i,
  input  logic        inv_all_i,
  output logic [31:0] instr_f_o,
  output logic        instr_miss_f_o,
  output logic        instr_cache_rep_en_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rvalid_i
);

  localparam int IDX_W = idx_w(SETS);
  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int TAG_W = tag_w(SETS, LINE_WORDS);
  localparam int LINE_W = LINE_WORDS * 32;

  icache_state_t state, state_nx;

  logic [OFF_W-1:0]  beat;
  logic [LINE_W-1:0] fill_buf;
  logic [TAG_W-1:0]  fill_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic              inv_pend;

  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic             unused_byte;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic             hit;
  logic             we;
  logic             clear_all;

  assign tag = pc_f_i[31 -: TAG_W];
  assign idx = pc_f_i[OFF_W+2 +: IDX_W];
  assign off = pc_f_i[2 +: OFF_W];
  assign unused_byte = ^pc_f_i[1:0];

  // A pending invalidate forces a miss even if the tag matches.
  assign hit = rd_valid && (rd_tag == tag) && !inv_pend;

  assign mem_addr_o = {fill_tag, fill_idx, beat, 2'b00};

  always_comb begin
    state_nx = state;
    instr_miss_f_o = 1'b1;
    instr_cache_rep_en_o = 1'b0;
    mem_req_o = 1'b0;
    we = 1'b0;
    clear_all = 1'b0;
    unique case (state)
      IC_IDLE: begin
        instr_miss_f_o = !hit;
        clear_all = inv_all_i || inv_pend;
        if (!hit) state_nx = IC_REFILL;
      end
      IC_REFILL: begin
        mem_req_o = 1'b1;
        if (mem_rvalid_i && (&beat)) state_nx = IC_COMMIT;
      end
      IC_COMMIT: begin
        instr_cache_rep_en_o = 1'b1;
        we = 1'b1;
        state_nx = IC_IDLE;
      end
      default: state_nx = IC_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= IC_IDLE;
      beat     <= '0;
      fill_tag <= '0;
      fill_idx <= '0;
      fill_buf <= '0;
      inv_pend <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IC_IDLE && !hit) begin
        fill_tag <= tag;
        fill_idx <= idx;
        beat     <= '0;
      end
      if (state == IC_REFILL && mem_rvalid_i) begin
        fill_buf[{beat, 5'b0} +: 32] <= mem_rdata_i;
        beat <= beat + 1'b1;
      end
      if (state == IC_IDLE) inv_pend <= 1'b0;
      else if (inv_all_i) inv_pend <= 1'b1;
    end
  end

  icache_store #(
    .SETS(SETS),
    .LINE_WORDS(LINE_WORDS)
  ) u_store (
    .clk(clk_i),
    .reset(reset_i),
    .rd_idx(idx),
    .rd_off(off),
    .rd_valid(rd_valid),
    .rd_tag(rd_tag),
    .rd_data(instr_f_o),
    .we(we),
    .wr_idx(fill_idx),
    .wr_tag(fill_tag),
    .wr_line(fill_buf),
    .clear_all(clear_all)
  );

endmodule

// File: tb/tb_icache_l1.sv
// Scoreboard bench for icache_l1: memory is a fixed hash of the address,
// every returned word and every refill beat is checked against it.
module tb_icache_l1;

  logic        clk_i;
  logic        reset_i;
  logic [31:0] pc_f_i;
  logic        inv_all_i;
  logic [31:0] instr_f_o;
  logic        instr_miss_f_o;
  logic        instr_cache_rep_en_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i;
  logic        mem_rvalid_i;

  icache_l1 dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .pc_f_i(pc_f_i),
    .inv_all_i(inv_all_i),
    .instr_f_o(instr_f_o),
    .instr_miss_f_o(instr_miss_f_o),
    .instr_cache_rep_en_o(instr_cache_rep_en_o),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_rvalid_i(mem_rvalid_i)
  );

  int checks = 0;
  int failures = 0;
  int rep_cnt = 0;
  int rv_mode = 0;
  int gap = 0;
  bit acc;
  logic [31:0] exp_q[$];
  logic [31:0] sweep [3] = '{32'h44, 32'h48, 32'h4C};

  // monitor state
  logic        m_idle;
  logic        prev_idle = 1'b1;
  logic        prev_miss = 1'b0;
  logic        prev_rep = 1'b0;
  logic [31:0] prev_pc = '0;
  logic        fence_prev = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] burst_base = '0;
  int          beat = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] memf(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'h00A0_00A0;
  endfunction

  function automatic logic [31:0] lbase(input logic [31:0] a);
    return {a[31:4], 4'b0000};
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] a;
    a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 4)
      | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
    return a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    acc = (exp_q.size() == 0);
    if (acc) exp_q.push_back(memf(pc_f_i));
    case (rv_mode)
      0: mem_rvalid_i = 1'b1;
      1: begin
        mem_rvalid_i = (gap == 0);
        gap = (gap + 1) % 4;
      end
      default: mem_rvalid_i = ($urandom_range(0, 99) < 60);
    endcase
    mem_rdata_i = mem_req_o ? memf(mem_addr_o) : $urandom();
  endtask

  task automatic set_pc(input logic [31:0] a);
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    pc_f_i = a;
    exp_q.push_back(memf(a));
  endtask

  task automatic wait_hit(output int n, input int lim);
    n = 0;
    while (n < lim) begin
      @(negedge clk_i);
      if (!instr_miss_f_o) break;
      n++;
      if (n < lim) tick();
    end
  endtask

  always @(negedge clk_i) begin
    if (reset_i) begin
      prev_idle = 1'b1;
      prev_miss = 1'b0;
      prev_rep = 1'b0;
      fence_prev = 1'b0;
      pend = 1'b0;
      beat = 0;
    end else begin
      m_idle = !mem_req_o && !instr_cache_rep_en_o;
      if (fence_prev || (pend && m_idle))
        chk("fence_forces_miss", instr_miss_f_o, 1'b1);
      else if (prev_rep && lbase(pc_f_i) == burst_base)
        chk("hit_after_commit", instr_miss_f_o, 1'b0);
      if (m_idle) pend = 1'b0;
      if (!m_idle) chk("busy_miss", instr_miss_f_o, 1'b1);
      if (prev_idle && prev_miss) chk("miss_starts_refill", mem_req_o, 1'b1);
      if (prev_idle && mem_req_o) begin
        burst_base = lbase(prev_pc);
        beat = 0;
      end
      if (mem_req_o) begin
        chk("refill_addr", mem_addr_o, burst_base + 32'(beat * 4));
        if (mem_rvalid_i) beat++;
      end
      if (instr_cache_rep_en_o) begin
        chk("commit_after_last_beat", beat, 4);
        chk("commit_no_req", mem_req_o, 1'b0);
        rep_cnt++;
      end
      if (!instr_miss_f_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_hit act=%h exp=none t=%0t", instr_f_o, $time);
        end else begin
          chk("instr", instr_f_o, exp_q.pop_front());
        end
      end
      fence_prev = inv_all_i && m_idle;
      if (inv_all_i && !m_idle) pend = 1'b1;
      prev_idle = m_idle;
      prev_miss = instr_miss_f_o;
      prev_rep = instr_cache_rep_en_o;
      prev_pc = pc_f_i;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r0;
    int beats;
    reset_i = 1'b1;
    pc_f_i = 32'h40;
    inv_all_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    exp_q.push_back(memf(32'h40));
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_miss", instr_miss_f_o, 1'b1);
    chk("rst_req", mem_req_o, 1'b0);
    chk("rst_rep", instr_cache_rep_en_o, 1'b0);
    tick();
    reset_i = 1'b0;

    // cold miss
    r0 = rep_cnt;
    wait_hit(n, 30);
    chk("cold_miss_cycles", n, 6);
    chk("cold_rep_pulses", rep_cnt - r0, 1);

    // hit sweep
    foreach (sweep[i]) begin
      tick();
      set_pc(sweep[i]);
      @(negedge clk_i);
      chk("hit_sweep_miss", instr_miss_f_o, 1'b0);
      chk("hit_sweep_req", mem_req_o, 1'b0);
    end

    // conflict eviction
    tick();
    set_pc(32'h1040);
    r0 = rep_cnt;
    wait_hit(n, 30);
    chk("conflict_cycles", n, 6);
    chk("conflict_rep", rep_cnt - r0, 1);
    tick();
    set_pc(32'h40);
    wait_hit(n, 30);
    chk("evicted_remiss", n, 6);

    // redirect mid-refill with stalled memory
    tick();
    rv_mode = 1;
    gap = 0;
    set_pc(32'h80);
    r0 = rep_cnt;
    beats = 0;
    for (int i = 0; i < 40 && beats < 2; i++) begin
      @(negedge clk_i);
      if (mem_req_o && mem_rvalid_i) beats++;
      tick();
    end
    set_pc(32'h200);
    wait_hit(n, 200);
    chk("redirect_refills", rep_cnt - r0, 2);
    rv_mode = 0;
    tick();
    set_pc(32'h80);
    @(negedge clk_i);
    chk("redirect_fill_kept", instr_miss_f_o, 1'b0);

    // fence.i in IDLE
    tick();
    set_pc(32'h40);
    inv_all_i = 1'b1;
    @(negedge clk_i);
    chk("fence_same_cycle_hit", instr_miss_f_o, 1'b0);
    tick();
    inv_all_i = 1'b0;
    @(negedge clk_i);
    chk("fence_idle_miss", instr_miss_f_o, 1'b1);
    tick();
    wait_hit(n, 30);
    chk("fence_refill", n, 5);

    // fence.i during REFILL
    tick();
    set_pc(32'h1040);
    r0 = rep_cnt;
    tick();
    inv_all_i = 1'b1;
    tick();
    inv_all_i = 1'b0;
    for (int i = 0; i < 30 && rep_cnt == r0; i++) begin
      @(negedge clk_i);
      tick();
    end
    chk("fence_pend_commit", rep_cnt - r0, 1);
    @(negedge clk_i);
    chk("fence_pend_miss", instr_miss_f_o, 1'b1);
    tick();
    wait_hit(n, 30);
    chk("fence_pend_refill", n, 5);

    // reset mid-refill
    tick();
    set_pc(32'h300);
    beats = 0;
    for (int i = 0; i < 30 && beats < 3; i++) begin
      @(negedge clk_i);
      if (mem_req_o && mem_rvalid_i) beats++;
      tick();
    end
    reset_i = 1'b1;
    #1;
    chk("reset_async_req", mem_req_o, 1'b0);
    chk("reset_miss", instr_miss_f_o, 1'b1);
    tick();
    reset_i = 1'b0;
    set_pc(32'h80);
    @(negedge clk_i);
    chk("reset_lines_invalid", instr_miss_f_o, 1'b1);
    tick();
    wait_hit(n, 30);
    chk("reset_fresh_refill", n, 5);
    tick();
    set_pc(32'h300);
    wait_hit(n, 30);
    chk("reset_partial_dropped", n, 6);

    // randomized traffic
    rv_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (acc || $urandom_range(0, 99) < 4) set_pc(rand_pc());
      inv_all_i = ($urandom_range(0, 99) < 2);
    end
    tick();
    inv_all_i = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
